// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared opcodes, FSM states and bubble encoding for the hazard controller
package pipe_hazard_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OPC_LOAD) || (op == OPC_STORE);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// rtl/pipe_hazard_ctrl_fwd_match.sv - M-to-X forwarding select for one source operand
module pipe_hazard_ctrl_fwd_match
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [31:0] i_inst_x,
  input  logic [31:0] i_inst_m,
  input  logic        i_rs_idx,
  output logic        o_fwd_sel
);

  logic [6:0] w_op_x;
  logic [6:0] w_op_m;
  logic [4:0] w_rd_m;
  logic [4:0] w_rs_x;
  logic       w_m_writes;
  logic       w_x_reads;
  logic       w_unused;

  assign w_op_x = i_inst_x[6:0];
  assign w_op_m = i_inst_m[6:0];
  assign w_rd_m = i_inst_m[11:7];
  assign w_unused = ^{i_inst_x[31:25], i_inst_x[14:7], i_inst_m[31:12]};

  always_comb begin
    w_m_writes = (w_op_m != OPC_BRANCH) && (w_op_m != OPC_STORE) && (w_rd_m != 5'd0);
    if (i_rs_idx) begin
      w_x_reads = (w_op_x == OPC_BRANCH) || (w_op_x == OPC_STORE) || (w_op_x == OPC_OP);
      w_rs_x    = i_inst_x[24:20];
    end else begin
      w_x_reads = !((w_op_x == OPC_LUI) || (w_op_x == OPC_AUIPC) || (w_op_x == OPC_JAL));
      w_rs_x    = i_inst_x[19:15];
    end
  end

  assign o_fwd_sel = w_m_writes && w_x_reads && (w_rs_x == w_rd_m);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/kill sequencing, stage-3 instruction register and perf counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REDIRECT_BUBBLES = 1,
  parameter logic [31:0] NOP              = NOP_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_inst_x,
  input  logic        i_br_taken_x,
  input  logic        i_imem_ready,
  input  logic        i_dmem_ready,
  output logic        o_stall,
  output logic        o_kill_d,
  output logic        o_fwd_a_sel,
  output logic        o_fwd_b_sel,
  output logic [31:0] o_inst_m,
  output logic [31:0] o_cycle_cnt,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);

  localparam logic [1:0] BUB_LOAD = 2'(REDIRECT_BUBBLES);

  state_e      r_state;
  logic [1:0]  r_bub_cnt;
  logic [31:0] r_inst_m;
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic        w_mem_stall;
  logic        w_in_redirect;

  assign w_mem_stall   = !i_imem_ready || (is_mem_op(i_inst_x[6:0]) && !i_dmem_ready);
  assign w_in_redirect = (r_state == ST_REDIRECT);

  assign o_stall  = w_mem_stall && !i_rst;
  assign o_kill_d = i_rst || (i_br_taken_x && !w_mem_stall && !w_in_redirect) || w_in_redirect;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_RUN;
      r_bub_cnt   <= 2'd0;
      r_inst_m    <= NOP;
      r_cycle_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_mem_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (!w_mem_stall) r_inst_m <= i_inst_x;
      case (r_state)
        ST_RUN, ST_MEM_WAIT: begin
          // A redirect seen while stalled is deferred: X holds the branch until release.
          if (w_mem_stall) begin
            r_state <= ST_MEM_WAIT;
          end else if (i_br_taken_x) begin
            r_state     <= ST_REDIRECT;
            r_bub_cnt   <= BUB_LOAD;
            r_flush_cnt <= r_flush_cnt + 32'd1;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_REDIRECT: begin
          if (!w_mem_stall) begin
            r_bub_cnt <= r_bub_cnt - 2'd1;
            if (r_bub_cnt <= 2'd1) r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  pipe_hazard_ctrl_fwd_match u_fwd_a (
    .i_inst_x (i_inst_x),
    .i_inst_m (r_inst_m),
    .i_rs_idx (1'b0),
    .o_fwd_sel(o_fwd_a_sel)
  );

  pipe_hazard_ctrl_fwd_match u_fwd_b (
    .i_inst_x (i_inst_x),
    .i_inst_m (r_inst_m),
    .i_rs_idx (1'b1),
    .o_fwd_sel(o_fwd_b_sel)
  );

  assign o_inst_m    = r_inst_m;
  assign o_cycle_cnt = r_cycle_cnt;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule
